// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding imem request, single-entry
// instruction holding register, redirect/kill handling and ebreak halt.
module ifu_fetch #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic            halted,
  output logic [31:0]     inst_count
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_HALT
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] ipc_q, ipc_d;
  logic            req_q, req_d;
  logic            iv_q, iv_d;
  logic            hlt_q, hlt_d;
  logic [31:0]     cnt_q, cnt_d;

  logic [XLEN-1:0] rd_pc;
  logic            take;

  assign rd_pc = {redirect_pc[XLEN-1:2], 2'b00};
  assign take  = iv_q & inst_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_REQ: begin
        if (redirect_valid) begin
          pc_d = rd_pc;
        end
        if (imem_req_ready) begin
          state_d = S_WAIT;
          kill_d  = redirect_valid;
        end
      end
      S_WAIT: begin
        // A response in the redirect cycle is the stale one; drop it here.
        if (redirect_valid) begin
          pc_d = rd_pc;
          if (imem_resp_valid) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            kill_d = 1'b1;
          end
        end else if (imem_resp_valid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            inst_d  = imem_resp_data;
            ipc_d   = pc_q;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (take && halt) begin
          cnt_d   = cnt_q + 32'd1;
          state_d = S_HALT;
        end else if (redirect_valid) begin
          pc_d    = rd_pc;
          state_d = S_REQ;
        end else if (take) begin
          pc_d    = pc_q + XLEN'(4);
          cnt_d   = cnt_q + 32'd1;
          state_d = S_REQ;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
    endcase
    req_d = (state_d == S_REQ);
    iv_d  = (state_d == S_HOLD);
    hlt_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
      inst_q  <= '0;
      ipc_q   <= '0;
      req_q   <= 1'b1;
      iv_q    <= 1'b0;
      hlt_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
      req_q   <= req_d;
      iv_q    <= iv_d;
      hlt_q   <= hlt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_req_valid = req_q;
  assign imem_addr      = pc_q;
  assign inst_valid     = iv_q;
  assign inst           = inst_q;
  assign inst_pc        = ipc_q;
  assign halted         = hlt_q;
  assign inst_count     = cnt_q;

endmodule
